kp_scan_display: RTL and testbench

//  Parametrised keypad controller: scans a ROWS x COLS matrix keypad, debounces and decodes one key,

---
 rtl/kp_scan_display.sv | 203 ++++++++++++++++++++
 tb/tb_kp_scan_display.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/kp_scan_display.sv
// Matrix keypad scanner/debouncer feeding a BCD shift register and a multiplexed 7-segment display.
// Optional build macro KP_AUTOREPEAT_EN adds auto-repeat for held digit keys.
module kp_scan_display #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int DIGITS       = 3,
  parameter int ROW_HOLD     = 2,
  parameter int DEBOUNCE_CYC = 4,
  parameter int REFRESH_CYC  = 4,
  parameter int REPEAT_CYC   = 250
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [COLS-1:0]   K_I,
  output logic [ROWS-1:0]   K_O,
  output logic [6:0]        SEG,
  output logic [DIGITS-1:0] COM,
  output logic              KEY_VALID,
  output logic [3:0]        KEY_CODE
);

  // state    | meaning
  // SCAN     | walk rows, sample each after its hold time
  // DEBOUNCE | row held, waiting for a stable low column
  // ACCEPT   | one cycle: emit key event and apply action
  // WAIT_REL | row held, waiting for a stable release
  typedef enum logic [1:0] {SCAN, DEBOUNCE, ACCEPT, WAIT_REL} state_t;

  // Row hold also covers the two synchroniser stages so every sample belongs to the driven row.
  localparam int HOLD_W = $clog2(ROW_HOLD + 2);
  localparam int DEB_W  = $clog2(DEBOUNCE_CYC + 1);
  localparam int REF_W  = $clog2(REFRESH_CYC + 1);
  localparam int SEL_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(ROW_HOLD + 1);
  localparam logic [DEB_W-1:0]  DEB_LOAD  = DEB_W'(DEBOUNCE_CYC - 1);
  localparam logic [REF_W-1:0]  REF_LOAD  = REF_W'(REFRESH_CYC - 1);

  state_t state, state_nxt;
  logic [COLS-1:0] k_s1, k_s2;
  logic [1:0] row, col, low_col, row_inc;
  logic any_low, same_low, fire, repeat_fire, is_digit, is_clr;
  logic [3:0] key_val;
  logic [HOLD_W-1:0] hold_cnt;
  logic [DEB_W-1:0] deb_cnt;
  logic [REF_W-1:0] ref_cnt;
  logic [SEL_W-1:0] dig_sel;
  logic [DIGITS-1:0][3:0] digits;

  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      k_s1 <= '1;
      k_s2 <= '1;
    end else begin
      k_s1 <= K_I;
      k_s2 <= k_s1;
    end

  always_comb begin
    low_col = '0;
    any_low = 1'b0;
    for (int c = COLS - 1; c >= 0; c--)
      if (!k_s2[c]) begin
        low_col = 2'(c);
        any_low = 1'b1;
      end
  end

  assign same_low = any_low && (low_col == col);
  assign row_inc  = (row == 2'(ROWS - 1)) ? 2'd0 : row + 2'd1;

  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) state <= SCAN;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      SCAN:     if (hold_cnt == '0 && any_low) state_nxt = DEBOUNCE;
      DEBOUNCE: if (!same_low) state_nxt = SCAN;
                else if (deb_cnt == '0) state_nxt = ACCEPT;
      ACCEPT:   state_nxt = WAIT_REL;
      WAIT_REL: if (!any_low && deb_cnt == '0) state_nxt = SCAN;
      default:  state_nxt = SCAN;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      row      <= '0;
      col      <= '0;
      hold_cnt <= '0;
      deb_cnt  <= '0;
    end else begin
      case (state)
        SCAN:
          if (hold_cnt != '0) hold_cnt <= hold_cnt - HOLD_W'(1);
          else if (any_low) begin
            col     <= low_col;
            deb_cnt <= DEB_LOAD;
          end else begin
            row      <= row_inc;
            hold_cnt <= HOLD_LOAD;
          end
        DEBOUNCE:
          if (!same_low) begin
            row      <= row_inc;
            hold_cnt <= HOLD_LOAD;
          end else if (deb_cnt != '0) deb_cnt <= deb_cnt - DEB_W'(1);
        ACCEPT: deb_cnt <= DEB_LOAD;
        WAIT_REL:
          if (any_low) deb_cnt <= DEB_LOAD;
          else if (deb_cnt != '0) deb_cnt <= deb_cnt - DEB_W'(1);
          else begin
            row      <= row_inc;
            hold_cnt <= HOLD_LOAD;
          end
        default: ;
      endcase
    end

  always_comb begin
    key_val  = '0;
    is_digit = 1'b0;
    is_clr   = 1'b0;
    if (row != 2'd3 && col != 2'd3) begin
      key_val  = ({2'b00, row} << 1) + {2'b00, row} + {2'b00, col} + 4'd1;
      is_digit = 1'b1;
    end else if (row == 2'd3 && col == 2'd1) begin
      is_digit = 1'b1;
    end else if (row == 2'd3 && col == 2'd0) begin
      is_clr = 1'b1;
    end
  end

`ifdef KP_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYC + 1);
  localparam logic [REP_W-1:0] REP_LOAD = REP_W'(REPEAT_CYC - 1);
  logic [REP_W-1:0] rep_cnt;

  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) rep_cnt <= '0;
    else if (state == ACCEPT) rep_cnt <= REP_LOAD;
    else if (state == WAIT_REL) begin
      if (!same_low || rep_cnt == '0) rep_cnt <= REP_LOAD;
      else rep_cnt <= rep_cnt - REP_W'(1);
    end

  assign repeat_fire = (state == WAIT_REL) && same_low && (rep_cnt == '0) && is_digit;
`else
  assign repeat_fire = 1'b0;
`endif

  assign fire = (state == ACCEPT) || repeat_fire;

  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      KEY_VALID <= 1'b0;
      KEY_CODE  <= '0;
      digits    <= '1;
    end else begin
      KEY_VALID <= fire;
      if (fire) begin
        KEY_CODE <= {row, col};
        if (is_clr) digits <= '1;
        else if (is_digit) begin
          for (int i = DIGITS - 1; i > 0; i--) digits[i] <= digits[i-1];
          digits[0] <= key_val;
        end
      end
    end

  // Display refresh free-runs regardless of keypad activity.
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      ref_cnt <= '0;
      dig_sel <= '0;
    end else if (ref_cnt != '0) ref_cnt <= ref_cnt - REF_W'(1);
    else begin
      ref_cnt <= REF_LOAD;
      dig_sel <= (dig_sel == SEL_W'(DIGITS - 1)) ? '0 : dig_sel + SEL_W'(1);
    end

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  assign K_O = ~(ROWS'(1) << row);
  assign COM = ~(DIGITS'(1) << dig_sel);
  assign SEG = seg_decode(digits[dig_sel]);

endmodule

// File: tb/tb_kp_scan_display.sv
// Scoreboard bench for kp_scan_display: key events checked by a monitor against a queue of expected codes.
module tb_kp_scan_display;
  localparam int ROWS = 4, COLS = 4, DIGITS = 3, ROW_HOLD = 2;
  localparam int DEBOUNCE_CYC = 4, REFRESH_CYC = 4, REPEAT_CYC = 250;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic [COLS-1:0] K_I;
  logic [ROWS-1:0] K_O;
  logic [6:0] SEG;
  logic [DIGITS-1:0] COM;
  logic KEY_VALID;
  logic [3:0] KEY_CODE;

  int n_tests = 0;
  int n_fail = 0;
  logic [3:0] exp_q[$];

  logic ka_down = 1'b0, kb_down = 1'b0;
  int ka_row = 0, ka_col = 0, kb_row = 0, kb_col = 0;

  kp_scan_display #(
    .ROWS(ROWS), .COLS(COLS), .DIGITS(DIGITS), .ROW_HOLD(ROW_HOLD),
    .DEBOUNCE_CYC(DEBOUNCE_CYC), .REFRESH_CYC(REFRESH_CYC), .REPEAT_CYC(REPEAT_CYC)
  ) dut (
    .CLK(CLK), .RESET(RESET), .K_I(K_I), .K_O(K_O), .SEG(SEG), .COM(COM),
    .KEY_VALID(KEY_VALID), .KEY_CODE(KEY_CODE)
  );

  always #5 CLK = ~CLK;

  // Keypad matrix: a pressed key pulls its column low only while its row is driven.
  always_comb begin
    K_I = '1;
    if (ka_down && !K_O[ka_row]) K_I[ka_col] = 1'b0;
    if (kb_down && !K_O[kb_row]) K_I[kb_col] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  always @(negedge CLK) begin : monitor
    logic [3:0] e;
    if (RESET && KEY_VALID) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL key_event: unexpected KEY_VALID with code %0h, required none", KEY_CODE);
      end else begin
        e = exp_q.pop_front();
        check("key_code", {28'd0, KEY_CODE}, {28'd0, e});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic press(input int r, input int c, input int hold, input logic [3:0] code);
    exp_q.push_back(code);
    ka_row = r; ka_col = c; ka_down = 1'b1;
    tick(hold);
    ka_down = 1'b0;
    tick(25);
    check("event_consumed", exp_q.size(), 0);
  endtask

  // Watches a few refresh rounds: COM stepping/dwell and the segment pattern seen per digit.
  task automatic check_display(input string name, input logic [6:0] e2, input logic [6:0] e1,
                               input logic [6:0] e0);
    logic [6:0] seen [DIGITS];
    logic [6:0] req [DIGITS];
    logic [DIGITS-1:0] got, prev_com, nxt;
    int run;
    bit started;
    req[0] = e0; req[1] = e1; req[2] = e2;
    got = '0; prev_com = COM; run = 0; started = 0;
    for (int k = 0; k < DIGITS; k++) seen[k] = '0;
    for (int i = 0; i < 3 * DIGITS * REFRESH_CYC; i++) begin
      @(negedge CLK);
      run++;
      if (COM != prev_com) begin
        nxt = {prev_com[DIGITS-2:0], prev_com[DIGITS-1]};
        check({name, "_com_step"}, {29'd0, COM}, {29'd0, nxt});
        if (started) check({name, "_com_dwell"}, run, REFRESH_CYC);
        started = 1;
        run = 0;
        prev_com = COM;
      end
      for (int k = 0; k < DIGITS; k++)
        if (COM == ~(DIGITS'(1) << k)) begin
          seen[k] = SEG;
          got[k] = 1'b1;
        end
    end
    check({name, "_all_digits"}, {29'd0, got}, 32'h7);
    for (int k = 0; k < DIGITS; k++)
      check($sformatf("%s_seg%0d", name, k), {25'd0, seen[k]}, {25'd0, req[k]});
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int guard;
    #2 RESET = 1'b0;
    tick(3);
    // 1: reset values, idle display
    check("rst_k_o", {28'd0, K_O}, 32'hE);
    check("rst_com", {29'd0, COM}, 32'h6);
    check("rst_seg", {25'd0, SEG}, 32'h0);
    check("rst_valid", {31'd0, KEY_VALID}, 32'h0);
    check("rst_code", {28'd0, KEY_CODE}, 32'h0);
    RESET = 1'b1;
    check_display("idle", 7'h00, 7'h00, 7'h00);

    // 2: key 5
    press(1, 1, 40, 4'h5);
    check_display("key5", 7'h00, 7'h00, 7'h6D);

    // 3: 1,2,3,4 -> left to right 2,3,4
    press(0, 0, 40, 4'h0);
    press(0, 1, 40, 4'h1);
    press(0, 2, 40, 4'h2);
    press(1, 0, 40, 4'h4);
    check_display("shift", 7'h5B, 7'h4F, 7'h66);

    // 4: key 8 bouncing, then stable
    ka_row = 2; ka_col = 1;
    for (int i = 0; i < 15; i++) begin
      ka_down = ~ka_down;
      tick(2);
    end
    ka_down = 1'b0;
    tick(10);
    check("bounce_no_event", exp_q.size(), 0);
    press(2, 1, 40, 4'h9);
    check_display("key8", 7'h4F, 7'h66, 7'h7F);

    // 5: 9, ENT, CLR, two keys on one row, reset mid-debounce
    press(2, 2, 40, 4'hA);
    press(3, 3, 40, 4'hF);
    check_display("ent", 7'h66, 7'h7F, 7'h6F);
    press(3, 0, 40, 4'hC);
    check_display("clr", 7'h00, 7'h00, 7'h00);
    kb_row = 1; kb_col = 2; kb_down = 1'b1;
    press(1, 1, 40, 4'h5);
    kb_down = 1'b0;
    tick(25);
    check_display("two_keys", 7'h00, 7'h00, 7'h6D);

    ka_row = 1; ka_col = 2;
    guard = 0;
    while (K_O == 4'b1101 && guard < 64) begin tick(1); guard++; end
    check("wait_row_leave", guard < 64, 1);
    ka_down = 1'b1;
    guard = 0;
    while (K_O != 4'b1101 && guard < 64) begin tick(1); guard++; end
    check("wait_row_enter", guard < 64, 1);
    tick(6);
    RESET = 1'b0;
    #1;
    check("mid_rst_k_o", {28'd0, K_O}, 32'hE);
    check("mid_rst_com", {29'd0, COM}, 32'h6);
    check("mid_rst_seg", {25'd0, SEG}, 32'h0);
    check("mid_rst_valid", {31'd0, KEY_VALID}, 32'h0);
    check("mid_rst_code", {28'd0, KEY_CODE}, 32'h0);
    ka_down = 1'b0;
    tick(2);
    RESET = 1'b1;
    tick(30);
    check("mid_rst_no_event", exp_q.size(), 0);
    check("mid_rst_code_hold", {28'd0, KEY_CODE}, 32'h0);

    // 6: hold 7 for two repeat periods plus margin
`ifdef KP_AUTOREPEAT_EN
    exp_q.push_back(4'h8);
    exp_q.push_back(4'h8);
    press(2, 0, 2 * REPEAT_CYC + 60, 4'h8);
    check_display("hold7", 7'h07, 7'h07, 7'h07);
`else
    press(2, 0, 2 * REPEAT_CYC + 60, 4'h8);
    check_display("hold7", 7'h00, 7'h00, 7'h07);
`endif

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
